// File: rtl/pendig_argmax_seq.sv
// Sequential argmax over the per-class popcounts of the pendigits BNN classifier.
// One comparator scans the captured scores, one class per clock, then offers the result.
module pendig_argmax_seq #(
  parameter int NCLASS = 10,
  parameter int SW     = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NCLASS*SW-1:0]       scores,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(NCLASS)-1:0]  out_class,
  output logic [SW-1:0]              out_score
);

  localparam int IW = $clog2(NCLASS);
  localparam logic [IW-1:0] LAST = IW'(NCLASS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [SW-1:0] cap [NCLASS];
  logic [IW-1:0] idx;
  logic [SW-1:0] best;
  logic [IW-1:0] best_idx;

  logic [SW-1:0] cur;
  logic          take;
  logic          last;
  logic [SW-1:0] win_score;
  logic [IW-1:0] win_idx;

  // Strict greater-than keeps the lower index on ties.
  assign cur       = cap[idx];
  assign take      = cur > best;
  assign last      = (idx == LAST);
  assign win_score = take ? cur : best;
  assign win_idx   = take ? idx : best_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SCAN;
      end
      SCAN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are loaded only on the final scan edge so they hold through the next scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCLASS; i++) cap[i] <= '0;
      idx       <= '0;
      best      <= '0;
      best_idx  <= '0;
      out_class <= '0;
      out_score <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < NCLASS; i++) cap[i] <= scores[i*SW +: SW];
            best     <= scores[SW-1:0];
            best_idx <= '0;
            idx      <= IW'(1);
          end
        end
        SCAN: begin
          best     <= win_score;
          best_idx <= win_idx;
          if (last) begin
            out_class <= win_idx;
            out_score <= win_score;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pendig_argmax_seq.sv
// Directed and randomised checks of pendig_argmax_seq against a first-index argmax model.
module tb_pendig_argmax_seq;

  localparam int NCLASS = 10;
  localparam int SW     = 5;
  localparam int IW     = 4;
  localparam int NRAND  = 1000;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [NCLASS*SW-1:0] scores;
  logic                 out_valid;
  logic                 out_ready;
  logic [IW-1:0]        out_class;
  logic [SW-1:0]        out_score;

  int tests;
  int fails;

  pendig_argmax_seq #(.NCLASS(NCLASS), .SW(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .scores    (scores),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Every class gets fill, then up to two classes are overridden (negative class = unused).
  function automatic logic [NCLASS*SW-1:0] mk(input int fill, input int c1, input int v1,
                                               input int c2, input int v2);
    logic [NCLASS*SW-1:0] v;
    for (int i = 0; i < NCLASS; i++) v[i*SW +: SW] = SW'(fill);
    if (c1 >= 0) v[c1*SW +: SW] = SW'(v1);
    if (c2 >= 0) v[c2*SW +: SW] = SW'(v2);
    return v;
  endfunction

  function automatic logic [IW+SW-1:0] refArgmax(input logic [NCLASS*SW-1:0] v);
    logic [SW-1:0] b;
    logic [IW-1:0] bi;
    b  = v[SW-1:0];
    bi = '0;
    for (int i = 1; i < NCLASS; i++)
      if (v[i*SW +: SW] > b) begin
        b  = v[i*SW +: SW];
        bi = IW'(i);
      end
    return {bi, b};
  endfunction

  // Offers a vector, then waits for out_valid and returns the edges counted after acceptance.
  task automatic applyStimulus(input logic [NCLASS*SW-1:0] v, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    scores   = v;
    @(negedge clk);
    in_valid = 1'b0;
    scores   = mk(31, -1, 0, -1, 0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runDirected(input string tag, input logic [NCLASS*SW-1:0] v,
                             input int exp_class, input int exp_score);
    int lat;
    applyStimulus(v, lat);
    checkOutput({tag, "_latency"}, lat, NCLASS - 1);
    checkOutput({tag, "_valid"}, out_valid, 1);
    checkOutput({tag, "_class"}, out_class, exp_class);
    checkOutput({tag, "_score"}, out_score, exp_score);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, out_valid, 0);
    checkOutput({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    int sent;
    int got;
    logic [IW+SW-1:0] expq [$];
    tests = 0;
    fails = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    scores    = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #1;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_class", out_class, 0);
    checkOutput("reset_out_score", out_score, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with no in_valid must not start anything.
    repeat (4) @(negedge clk);
    checkOutput("idle_out_valid", out_valid, 0);
    checkOutput("idle_in_ready", in_ready, 1);

    runDirected("unique7", mk(3, 7, 20, -1, 0), 7, 20);
    runDirected("all9", mk(9, -1, 0, -1, 0), 0, 9);
    runDirected("tie3_8", mk(0, 3, 31, 8, 31), 3, 31);
    runDirected("last9", mk(0, 9, 1, -1, 0), 9, 1);
    runDirected("allzero", mk(0, -1, 0, -1, 0), 0, 0);

    // Backpressure: result holds and new offers are ignored.
    applyStimulus(mk(0, 4, 25, 6, 24), lat);
    checkOutput("bp_class", out_class, 4);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      scores   = mk(1, 1, 30, -1, 0);
      @(negedge clk);
      checkOutput("bp_hold_valid", out_valid, 1);
      checkOutput("bp_hold_class", out_class, 4);
      checkOutput("bp_hold_score", out_score, 25);
      checkOutput("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_release_valid", out_valid, 0);
    checkOutput("bp_release_ready", in_ready, 1);
    runDirected("second2", mk(5, 2, 17, -1, 0), 2, 17);

    // Asynchronous reset in the middle of a scan.
    in_valid = 1'b1;
    scores   = mk(0, 8, 29, -1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_out_class", out_class, 0);
    checkOutput("midrst_out_score", out_score, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    runDirected("after_rst5", mk(11, 5, 12, -1, 0), 5, 12);

    // Randomised regression with independent driver and consumer.
    sent = 0;
    got  = 0;
    fork
      begin
        for (int k = 0; k < NRAND; k++) begin
          int w;
          logic [NCLASS*SW-1:0] v;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          for (int i = 0; i < NCLASS; i++)
            v[i*SW +: SW] = SW'((k % 2 == 0) ? $urandom_range(0, 31) : $urandom_range(0, 3));
          in_valid = 1'b1;
          scores   = v;
          w = 0;
          while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
          end
          if (in_ready) begin
            expq.push_back(refArgmax(v));
            sent++;
          end
          @(negedge clk);
          in_valid = 1'b0;
        end
      end
      begin
        int cyc;
        cyc = 0;
        while (got < NRAND && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          out_ready = ($urandom_range(0, 2) != 0);
          if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
              checkOutput("rand_unexpected_output", 1, 0);
            end else begin
              logic [IW+SW-1:0] e;
              e = expq.pop_front();
              checkOutput("rand_class", out_class, e[IW+SW-1:SW]);
              checkOutput("rand_score", out_score, e[SW-1:0]);
            end
            got++;
          end
        end
        out_ready = 1'b0;
      end
    join
    checkOutput("rand_sent", sent, NRAND);
    checkOutput("rand_received", got, NRAND);
    checkOutput("rand_leftover", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pendig_argmax_seq.md
Name: pendig_argmax_seq

Overview:
- Sequential argmax stage directly downstream of the xnor/popcount classifier layer in the pendigits BNN.
- Accepts the packed per-class popcount vector (10 classes x 5 bits) through a valid/ready handshake.
- Scans the classes serially, one per clock, to keep the comparator count at one.
- Presents the winning class index and its score through a valid/ready output handshake.

Parameters:
- NCLASS, 10, number of classes; must be >= 2.
- SW, 5, width of one class score in bits (unsigned).
- Local, not overridable: IW = clog2(NCLASS), which is 4 at the default.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  scores holds a valid vector.
- in_ready  output  1  block can accept a vector.
- scores  input  NCLASS*SW  packed scores; class i occupies bits [i*SW +: SW].
- out_valid  output  1  out_class and out_score are valid.
- out_ready  input  1  consumer accepts the result.
- out_class  output  IW  index of the maximum score.
- out_score  output  SW  value of the maximum score.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, out_valid=0, out_class=0, out_score=0, scan index=0, captured scores cleared. A reset in any state, including mid-SCAN or DONE, discards the in-flight vector. Handshakes are ignored while rst_n is low.
- in_ready = (state==IDLE), combinational from state only; it does not depend on in_valid.
- FSM states are IDLE, SCAN and DONE.
- IDLE: on an edge with in_valid&in_ready, register all of scores. Set best_idx=0, best=scores[0], idx=1. Go to SCAN.
- SCAN: each edge compares captured score[idx] against best.
  - If strictly greater, best<=score[idx] and best_idx<=idx.
  - Ties keep the lower index.
  - When idx==NCLASS-1, that comparison completes and the FSM goes to DONE. Otherwise idx<=idx+1.
  - Changes on in_valid/scores during SCAN have no effect.
- DONE: out_valid=1, out_class=best_idx, out_score=best.
  - Outputs are stable while out_valid&!out_ready.
  - On an edge with out_valid&out_ready, out_valid<=0 and the FSM goes to IDLE.
  - No new vector is accepted in the same edge as the output handshake.
- Latency: with the accept edge as edge 0, out_valid is high after edge NCLASS-1 (9 at default). Minimum initiation interval is NCLASS+1 cycles: accept, NCLASS-1 scan edges, output handshake, return to IDLE.
- Arithmetic: unsigned SW-bit compare only. 0 and 2^SW-1 are legal scores, and no overflow is possible.
- out_class/out_score hold their last values after the output handshake until the next DONE. They are only meaningful while out_valid=1.
- in_valid deasserted in IDLE: the block stays in IDLE indefinitely with no state change.

Test Plan:
- Unique max: class 7=20, all others 3; in_valid one cycle -> out_valid high 9 edges after accept, out_class=7, out_score=20.
- All scores 9 -> out_class=0, out_score=9. Then ties: class 3=31 and class 8=31, others 0 -> out_class=3, out_score=31.
- Max in last slot: class 9=1, others 0 -> out_class=9, out_score=1. Then all zero -> out_class=0, out_score=0.
- Backpressure: out_ready low for 5 cycles after out_valid.
  - out_valid, out_class and out_score stay stable; in_ready=0; in_valid pulses with a new vector are ignored.
  - Raising out_ready -> out_valid=0 and in_ready=1 the next cycle.
  - A second vector (class 2=17, others 5) is then accepted and yields out_class=2.
- Reset mid-operation:
  - Pull rst_n low at scan edge 4 -> immediately out_valid=0, out_class=0, out_score=0, in_ready=1 with no clock needed.
  - After release, a new vector (class 5=12, others 11) -> out_class=5 with normal 9-edge latency.
- Randomised regression: 1000 random vectors with random in_valid/out_ready gaps, checked against a reference model (first-index argmax). Require exactly one output per accepted vector and no duplicate or lost results.
